// File: rtl/rf_alu_sequencer_if.sv
// Instruction handshake, register-file port and status bundle for the sequencer.
interface rf_alu_sequencer_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
);
    logic              instr_valid;
    logic              instr_ready;
    logic [2:0]        op;
    logic [ADDR_W-1:0] rd;
    logic [ADDR_W-1:0] rs1;
    logic [ADDR_W-1:0] rs2;
    logic [DATA_W-1:0] imm;
    logic [ADDR_W-1:0] rf_num_r1;
    logic [ADDR_W-1:0] rf_num_r2;
    logic [DATA_W-1:0] rf_dout1;
    logic [DATA_W-1:0] rf_dout2;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_w1;
    logic [DATA_W-1:0] rf_din;
    logic [DATA_W-1:0] result;
    logic              flag_z;
    logic              flag_c;
    logic              done;
    logic              busy;
    logic [15:0]       retired;

    // Sequencer side
    modport master (
        input  instr_valid, op, rd, rs1, rs2, imm, rf_dout1, rf_dout2,
        output instr_ready, rf_num_r1, rf_num_r2, rf_we, rf_w1, rf_din,
        output result, flag_z, flag_c, done, busy, retired
    );

    // Instruction source / register-file side
    modport slave (
        output instr_valid, op, rd, rs1, rs2, imm, rf_dout1, rf_dout2,
        input  instr_ready, rf_num_r1, rf_num_r2, rf_we, rf_w1, rf_din,
        input  result, flag_z, flag_c, done, busy, retired
    );
endinterface

// File: rtl/rf_alu_sequencer.sv
// Sequences one instruction at a time: READ (RF address) -> EXEC (ALU) -> WB (RF write).
module rf_alu_sequencer #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    rf_alu_sequencer_if.master    bus
);
    typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

    state_t            state_q, state_d;
    logic [2:0]        op_q;
    logic [ADDR_W-1:0] rd_q, rs1_q, rs2_q;
    logic [DATA_W-1:0] imm_q;
    logic [DATA_W-1:0] result_q;
    logic              z_q, c_q;
    logic [15:0]       retired_q;

    logic              accept;
    logic              wb_d, busy_d;
    logic [DATA_W-1:0] alu_res;
    logic              alu_c;
    logic [DATA_W:0]   sum;

    // Ready is gated by reset so nothing is accepted while reset is held.
    assign bus.instr_ready = (state_q == IDLE) && RST_N;
    assign accept          = bus.instr_valid && bus.instr_ready;

    // Next-state and per-state control outputs.
    always_comb begin
        state_d = state_q;
        wb_d    = 1'b0;
        busy_d  = 1'b1;
        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (accept) state_d = READ;
            end
            READ: state_d = EXEC;
            EXEC: state_d = WB;
            WB: begin
                wb_d    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // ALU on the RF read data, which is valid while in EXEC.
    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        sum     = {1'b0, bus.rf_dout1} + {1'b0, bus.rf_dout2};
        case (op_q)
            3'd0: {alu_c, alu_res} = sum;
            3'd1: begin
                alu_res = bus.rf_dout1 - bus.rf_dout2;
                alu_c   = bus.rf_dout1 < bus.rf_dout2;
            end
            3'd2: alu_res = bus.rf_dout1 & bus.rf_dout2;
            3'd3: alu_res = bus.rf_dout1 | bus.rf_dout2;
            3'd4: alu_res = bus.rf_dout1 ^ bus.rf_dout2;
            3'd5: alu_res = bus.rf_dout1 << 1;
            3'd6: alu_res = bus.rf_dout1 >> 1;
            default: alu_res = imm_q;
        endcase
    end

    // State register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Instruction fields captured on accept; they also drive the RF read addresses.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            op_q  <= '0;
            rd_q  <= '0;
            rs1_q <= '0;
            rs2_q <= '0;
            imm_q <= '0;
        end else if (accept) begin
            op_q  <= bus.op;
            rd_q  <= bus.rd;
            rs1_q <= bus.rs1;
            rs2_q <= bus.rs2;
            imm_q <= bus.imm;
        end
    end

    // Result and flags registered at the EXEC->WB edge, held until the next EXEC.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            result_q <= '0;
            z_q      <= 1'b0;
            c_q      <= 1'b0;
        end else if (state_q == EXEC) begin
            result_q <= alu_res;
            z_q      <= (alu_res == '0);
            c_q      <= alu_c;
        end
    end

    // Retired count bumps as WB completes; wraps naturally.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)            retired_q <= '0;
        else if (state_q == WB) retired_q <= retired_q + 16'd1;
    end

    assign bus.rf_num_r1 = rs1_q;
    assign bus.rf_num_r2 = rs2_q;
    assign bus.rf_we     = wb_d;
    assign bus.done      = wb_d;
    assign bus.rf_w1     = rd_q;
    assign bus.rf_din    = result_q;
    assign bus.result    = result_q;
    assign bus.flag_z    = z_q;
    assign bus.flag_c    = c_q;
    assign bus.busy      = busy_d;
    assign bus.retired   = retired_q;
endmodule

// File: tb/tb_rf_alu_sequencer.sv
// Scoreboard bench: stimulus pushes expected writebacks, a negedge monitor pops and compares.
module tb_rf_alu_sequencer;
    localparam int DW = 16;
    localparam int AW = 3;

    logic CLK = 1'b0;
    logic RST_N = 1'b0;
    always #5 CLK = ~CLK;

    rf_alu_sequencer_if #(.DATA_W(DW), .ADDR_W(AW)) bus();
    rf_alu_sequencer #(.DATA_W(DW), .ADDR_W(AW)) dut (.CLK(CLK), .RST_N(RST_N), .bus(bus));

    typedef struct packed {
        logic [AW-1:0] rd;
        logic [DW-1:0] din;
        logic          z;
        logic          c;
        logic [15:0]   ret;
    } exp_t;

    exp_t sb[$];
    int   acc_q[$];
    int   acc_log[$];
    int   cyc = 0;
    int   we_cnt = 0;
    int   n_ret = 0;
    int   errors = 0;
    int   checks = 0;
    logic [DW-1:0] rf [8] = '{default: '0};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Register file model: 1-cycle synchronous read, synchronous write.
    always @(posedge CLK) begin
        bus.rf_dout1 <= rf[bus.rf_num_r1];
        bus.rf_dout2 <= rf[bus.rf_num_r2];
        if (bus.rf_we) rf[bus.rf_w1] <= bus.rf_din;
    end

    // Accept logger with a free-running edge counter.
    always @(posedge CLK) begin
        if (bus.instr_valid && bus.instr_ready) begin
            acc_q.push_back(cyc);
            acc_log.push_back(cyc);
        end
        cyc++;
    end

    // Monitor: compares every writeback against the scoreboard.
    always @(negedge CLK) begin
        exp_t e;
        if (RST_N) begin
            chk("busy_not_ready", bus.busy, !bus.instr_ready);
            if (bus.rf_we) we_cnt++;
            if (bus.done || bus.rf_we) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_wb: got rf_w1=%0h rf_din=%0h expected no writeback", bus.rf_w1, bus.rf_din);
                end else begin
                    e = sb.pop_front();
                    chk("wb_we", bus.rf_we, 1'b1);
                    chk("wb_done", bus.done, 1'b1);
                    chk("wb_addr", bus.rf_w1, e.rd);
                    chk("wb_data", bus.rf_din, e.din);
                    chk("result", bus.result, e.din);
                    chk("flag_z", bus.flag_z, e.z);
                    chk("flag_c", bus.flag_c, e.c);
                    chk("retired_in_wb", bus.retired, e.ret);
                    if (acc_q.size() > 0) chk("latency", cyc - acc_q.pop_front(), 3);
                end
            end
        end
    end

    task automatic send(input logic [2:0] op, input logic [AW-1:0] rd, input logic [AW-1:0] rs1,
                        input logic [AW-1:0] rs2, input logic [DW-1:0] imm, input logic [DW-1:0] din,
                        input logic z, input logic c, input bit push, input bit keep);
        exp_t e;
        @(negedge CLK);
        bus.op = op; bus.rd = rd; bus.rs1 = rs1; bus.rs2 = rs2; bus.imm = imm;
        bus.instr_valid = 1'b1;
        for (int i = 0; i < 20 && !bus.instr_ready; i++) @(negedge CLK);
        if (!bus.instr_ready) chk("accept_timeout", 0, 1);
        if (push) begin
            e.rd = rd; e.din = din; e.z = z; e.c = c; e.ret = n_ret[15:0];
            sb.push_back(e);
            n_ret++;
        end
        @(posedge CLK);
        #1;
        if (!keep) bus.instr_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 20 && bus.busy; i++) @(negedge CLK);
        @(negedge CLK);
        chk("idle_timeout", bus.busy, 1'b0);
    endtask

    initial begin
        int base;
        int we0;
        bus.instr_valid = 1'b0;
        bus.op = '0; bus.rd = '0; bus.rs1 = '0; bus.rs2 = '0; bus.imm = '0;
        repeat (2) @(negedge CLK);
        chk("rst_ready", bus.instr_ready, 1'b0);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_we", bus.rf_we, 1'b0);
        chk("rst_done", bus.done, 1'b0);
        chk("rst_retired", bus.retired, 16'h0);
        chk("rst_result", bus.result, 16'h0);
        chk("rst_flags", {bus.flag_z, bus.flag_c}, 2'b00);
        chk("rst_addrs", {bus.rf_num_r1, bus.rf_num_r2, bus.rf_w1}, 9'h0);
        RST_N = 1'b1;
        #1 chk("ready_after_rst", bus.instr_ready, 1'b1);

        // LDI r1 = 5: ready low through READ/EXEC/WB
        send(3'd7, 3'd1, 3'd0, 3'd0, 16'h0005, 16'h0005, 1'b0, 1'b0, 1, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            chk("ready_low_busy", bus.instr_ready, 1'b0);
        end
        @(negedge CLK);
        chk("ready_back", bus.instr_ready, 1'b1);
        chk("retired_1", bus.retired, 16'h1);

        // ADD wrapping to zero, SUB borrow, SHR1
        send(3'd7, 3'd2, 3'd0, 3'd0, 16'hFFFB, 16'hFFFB, 1'b0, 1'b0, 1, 0);
        send(3'd0, 3'd3, 3'd1, 3'd2, 16'h0000, 16'h0000, 1'b1, 1'b1, 1, 0);
        wait_idle();
        chk("r3_readback", rf[3], 16'h0000);
        send(3'd1, 3'd4, 3'd3, 3'd1, 16'h0000, 16'hFFFB, 1'b0, 1'b1, 1, 0);
        send(3'd6, 3'd5, 3'd4, 3'd0, 16'h0000, 16'h7FFD, 1'b0, 1'b0, 1, 0);

        // Same register as source and destination
        send(3'd7, 3'd2, 3'd0, 3'd0, 16'h8001, 16'h8001, 1'b0, 1'b0, 1, 0);
        send(3'd0, 3'd2, 3'd2, 3'd2, 16'h0000, 16'h0002, 1'b0, 1'b1, 1, 0);
        wait_idle();
        chk("r2_self_add", rf[2], 16'h0002);

        // XOR and AND
        send(3'd4, 3'd6, 3'd1, 3'd5, 16'h0000, 16'h7FF8, 1'b0, 1'b0, 1, 0);
        send(3'd2, 3'd7, 3'd4, 3'd5, 16'h0000, 16'h7FF9, 1'b0, 1'b0, 1, 0);
        wait_idle();
        chk("r6_xor", rf[6], 16'h7FF8);
        chk("r7_and", rf[7], 16'h7FF9);

        // Reset between instructions clears the retired count
        @(negedge CLK);
        RST_N = 1'b0;
        sb.delete(); acc_q.delete(); n_ret = 0;
        @(negedge CLK);
        RST_N = 1'b1;
        #1 chk("retired_cleared", bus.retired, 16'h0);

        // instr_valid held high across three instructions
        base = acc_log.size();
        send(3'd7, 3'd7, 3'd0, 3'd0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1, 1);
        send(3'd3, 3'd6, 3'd1, 3'd2, 16'h0000, 16'h0007, 1'b0, 1'b0, 1, 1);
        send(3'd5, 3'd0, 3'd4, 3'd0, 16'h0000, 16'hFFF6, 1'b0, 1'b0, 1, 0);
        wait_idle();
        if (acc_log.size() >= base + 3) begin
            chk("b2b_gap1", acc_log[base+1] - acc_log[base], 4);
            chk("b2b_gap2", acc_log[base+2] - acc_log[base+1], 4);
        end else chk("b2b_accepts", acc_log.size() - base, 3);
        chk("retired_3", bus.retired, 16'h3);
        chk("r0_shl", rf[0], 16'hFFF6);

        // Reset during EXEC of ADD r6: no write may happen
        we0 = we_cnt;
        send(3'd0, 3'd6, 3'd1, 3'd2, 16'h0000, 16'h0000, 1'b0, 1'b0, 0, 0);
        @(posedge CLK);
        #1 RST_N = 1'b0;
        #1;
        chk("abort_busy", bus.busy, 1'b0);
        chk("abort_result", bus.result, 16'h0);
        chk("abort_retired", bus.retired, 16'h0);
        chk("abort_we", bus.rf_we, 1'b0);
        acc_q.delete(); n_ret = 0;
        @(negedge CLK);
        RST_N = 1'b1;
        repeat (4) @(negedge CLK);
        chk("abort_no_write", we_cnt - we0, 0);
        chk("r6_unchanged", rf[6], 16'h0007);

        // Normal instruction after the aborted one
        send(3'd7, 3'd3, 3'd0, 3'd0, 16'h1234, 16'h1234, 1'b0, 1'b0, 1, 0);
        wait_idle();
        chk("r3_after_abort", rf[3], 16'h1234);
        chk("retired_after_abort", bus.retired, 16'h1);
        chk("sb_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/rf_alu_sequencer.md
Name: rf_alu_sequencer

Overview:
- Controller that sequences one register-operand instruction at a time through the 8x16 register file (synchronous 1-cycle read, synchronous write) and a built-in 16-bit ALU.
- It accepts an instruction over a valid/ready handshake, drives the RF read addresses, and computes the result from the RF read data.
- It writes the result back to the RF, then pulses done.
- It sits between the instruction source (top-level FSM or testbench) and the register file.

Parameters:
- DATA_W, 16, datapath / RF word width
- ADDR_W, 3, RF address width (2**ADDR_W registers)

Ports:
- CLK  in  1  clock, rising edge
- RST_N  in  1  asynchronous active-low reset
- instr_valid  in  1  instruction present
- instr_ready  out  1  sequencer can accept
- op  in  3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SHL1 (rs1<<1), 6 SHR1 (rs1>>1 logical), 7 LDI (imm)
- rd  in  ADDR_W  destination register
- rs1  in  ADDR_W  source register 1
- rs2  in  ADDR_W  source register 2
- imm  in  DATA_W  immediate, used by LDI only
- rf_num_r1  out  ADDR_W  RF read address 1
- rf_num_r2  out  ADDR_W  RF read address 2
- rf_dout1  in  DATA_W  RF read data 1, valid the cycle after its address is presented
- rf_dout2  in  DATA_W  RF read data 2, same timing
- rf_we  out  1  RF write enable
- rf_w1  out  ADDR_W  RF write address
- rf_din  out  DATA_W  RF write data
- result  out  DATA_W  last result, held until next EXEC
- flag_z  out  1  result == 0
- flag_c  out  1  ADD carry-out / SUB borrow; 0 for other ops
- done  out  1  one-cycle pulse, coincident with the writeback cycle
- busy  out  1  state != IDLE
- retired  out  16  count of completed instructions, wraps 0xFFFF->0x0000

Behaviour:
- States: IDLE, READ, EXEC, WB. Transitions:
  - IDLE -> READ on accept.
  - READ -> EXEC unconditionally.
  - EXEC -> WB unconditionally.
  - WB -> IDLE unconditionally.
- instr_ready = (state == IDLE) && RST_N. Accept = instr_valid && instr_ready at a rising edge.
- On accept, latch op, rd, rs1, rs2 and imm. Inputs are don't-care at all other times.
- rf_num_r1 and rf_num_r2 always drive the latched rs1 and rs2. They equal the new values throughout READ, so RF data is valid in EXEC.
- EXEC:
  - Compute the ALU result from rf_dout1, rf_dout2 and imm.
  - At the EXEC->WB edge, register result, flag_z and flag_c.
  - ADD: {c,res} = a+b, 17-bit.
  - SUB: res = a-b mod 2^16, c = (a<b).
  - Shifts discard the shifted-out bit, c=0.
  - LDI: res = imm, c=0.
  - LDI still traverses READ/EXEC, giving uniform latency.
- WB: rf_we=1, rf_w1=latched rd, rf_din=result, done=1. The retired counter increments at the WB->IDLE edge.
- rf_we and done are 0 in every state other than WB.
- Latency: accept edge to done high = 3 cycles. Throughput is one instruction per 4 cycles. instr_valid held high gives accepts 4 cycles apart.
- No hazards exist: the next READ occurs at least 2 edges after the previous RF write.
- rd may equal rs1 and/or rs2. Old values are read, and the new value is written in WB.
- Reset (asynchronous, any state) forces:
  - state to IDLE;
  - latched fields, result, flag_z, flag_c and retired to 0;
  - rf_we, done and busy to 0;
  - rf_num_r1, rf_num_r2 and rf_w1 to 0.
- An instruction interrupted by reset never writes the RF.
- instr_ready rises in the first cycle after RST_N deasserts.

Test Plan:
- Reset then LDI rd=1, imm=0x0005 -> instr_ready low for 3 cycles; WB cycle has rf_we=1, rf_w1=1, rf_din=0x0005, done=1; flag_z=0, flag_c=0; retired=1.
- LDI r2=0xFFFB, then ADD rd=3, rs1=1, rs2=2 -> result 0x0000, flag_z=1, flag_c=1; r3 reads back 0x0000.
- SUB rd=4, rs1=3, rs2=1 (0x0000-0x0005) -> result 0xFFFB, flag_c=1, flag_z=0. SHR1 rd=5, rs1=4 -> 0x7FFD, flag_c=0.
- ADD rd=2, rs1=2, rs2=2 with r2=0x8001 -> r2=0x0002, flag_c=1, showing the old value is read before the same-register write.
- instr_valid held high for 3 instructions -> accepts at edges 0, 4 and 8; done at cycles 3, 7 and 11; retired=3; busy low only in IDLE cycles.
- RST_N pulsed low during EXEC of ADD rd=6 -> rf_we never asserts, r6 unchanged, retired=0, result=0; the next LDI completes normally.
